// File: rtl/tmds_channel_decoder_pkg.sv
// Shared TMDS definitions: control tokens (also used by the transmitter)
// and the receive alignment state machine encoding.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Map the two control bits {c1,c0} to their 10-bit line token.
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Channel bus between the deserializer (master) and the TMDS channel
// decoder (slave): raw 10-bit words in, decoded pixel/control words out.
interface tmds_channel_decoder_if;
    logic [9:0] raw;
    logic       raw_valid;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic       de;
    logic       out_valid;
    logic       locked;
    logic [3:0] slip;

    modport master (
        output raw, raw_valid,
        input  data, c0, c1, de, out_valid, locked, slip
    );

    modport slave (
        input  raw, raw_valid,
        output data, c0, c1, de, out_valid, locked, slip
    );
endinterface

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: classifies a 10-bit aligned word as a
// control token or a data word and undoes the 8b/10b data encoding.
// Running disparity is not checked.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] w,
    output logic       is_ctrl,
    output logic [1:0] c,
    output logic [7:0] d
);

    logic [7:0] q;

    // Match the word against each of the four control tokens.
    always_comb begin
        is_ctrl = 1'b0;
        c       = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (w == ctrl_token(2'(k))) begin
                is_ctrl = 1'b1;
                c       = 2'(k);
            end
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q    = w[9] ? ~w[7:0] : w[7:0];
        d    = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel receiver: finds the 10-bit word boundary by hunting for
// runs of control tokens, holds lock while control periods keep arriving,
// and decodes each aligned word through a two-stage pipeline.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int DWELL     = 32,
    parameter int LOCK_CTRL = 8,
    parameter int TIMEOUT   = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tmds_channel_decoder_if.slave  bus
);

    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int RUN_W   = (LOCK_CTRL > 1) ? $clog2(LOCK_CTRL) : 1;
    localparam int IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_CTRL - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

    state_t             state;
    logic               locked;
    logic [3:0]         slip;
    logic [9:0]         prev;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic [IDLE_W-1:0]  idle_cnt;

    // Window: bit 0 is the earliest received; raw[9] never reaches a window
    // because the largest offset (9) tops out at bit 18 of {raw, prev}.
    logic [18:0] pair;
    logic [9:0]  w;
    logic        is_ctrl;
    logic [1:0]  ctrl_c;
    logic [7:0]  dec_d;

    logic        lock_now;
    logic        drop_now;
    logic        qual;

    logic        vld_p1;
    logic        qual_p1;
    logic        ctrl_p1;
    logic [1:0]  c_p1;
    logic [7:0]  d_p1;

    logic        vld_p2;
    logic        de_p2;
    logic        c0_p2;
    logic        c1_p2;
    logic [7:0]  data_p2;

    assign pair = {bus.raw[8:0], prev};
    assign w    = 10'(pair >> slip);

    tmds_word_decode u_word_decode (
        .w       (w),
        .is_ctrl (is_ctrl),
        .c       (ctrl_c),
        .d       (dec_d)
    );

    // Lock is gained on the LOCK_CTRL-th consecutive token and lost on the
    // TIMEOUT-th consecutive data word; the word causing either transition
    // is qualified by the state the FSM is entering.
    assign lock_now = (state == SEARCH) && is_ctrl && (run_cnt == RUN_LAST);
    assign drop_now = (state == LOCKED) && !is_ctrl && (idle_cnt == IDLE_LAST);
    assign qual     = lock_now || ((state == LOCKED) && !drop_now);

    // Remember the last valid raw word to form straddling windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 10'd0;
        end else if (bus.raw_valid) begin
            prev <= bus.raw;
        end
    end

    // Alignment FSM: dwell at each offset hunting for a token run, then
    // hold the offset until control periods stop arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            slip      <= 4'd0;
            dwell_cnt <= '0;
            run_cnt   <= '0;
            idle_cnt  <= '0;
        end else if (bus.raw_valid) begin
            case (state)
                SEARCH: begin
                    if (lock_now) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        dwell_cnt <= '0;
                        run_cnt   <= '0;
                        idle_cnt  <= '0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        slip      <= (slip == 4'd9) ? 4'd0 : slip + 4'd1;
                        dwell_cnt <= '0;
                        run_cnt   <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                        run_cnt   <= is_ctrl ? run_cnt + 1'b1 : '0;
                    end
                end
                LOCKED: begin
                    if (drop_now) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        dwell_cnt <= '0;
                        run_cnt   <= '0;
                        idle_cnt  <= '0;
                    end else if (is_ctrl) begin
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt  <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture classification, decoded byte and lock qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            qual_p1 <= 1'b0;
            ctrl_p1 <= 1'b0;
            c_p1    <= 2'b00;
            d_p1    <= 8'h00;
        end else begin
            vld_p1 <= bus.raw_valid;
            if (bus.raw_valid) begin
                qual_p1 <= qual;
                ctrl_p1 <= is_ctrl;
                c_p1    <= ctrl_c;
                d_p1    <= dec_d;
            end
        end
    end

    // Stage 2: publish qualified words; unqualified slots hold the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            de_p2   <= 1'b0;
            c0_p2   <= 1'b0;
            c1_p2   <= 1'b0;
            data_p2 <= 8'h00;
        end else begin
            vld_p2 <= vld_p1 && qual_p1;
            if (vld_p1 && qual_p1) begin
                de_p2 <= !ctrl_p1;
                if (ctrl_p1) begin
                    data_p2 <= 8'h00;
                    c0_p2   <= c_p1[0];
                    c1_p2   <= c_p1[1];
                end else begin
                    data_p2 <= d_p1;
                end
            end
        end
    end

    assign bus.data      = data_p2;
    assign bus.c0        = c0_p2;
    assign bus.c1        = c1_p2;
    assign bus.de        = de_p2;
    assign bus.out_valid = vld_p2;
    assign bus.locked    = locked;
    assign bus.slip      = slip;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: random and directed word
// streams compared cycle by cycle against a word-level reference model.
module tb_tmds_channel_decoder;

    localparam int DWELL     = 32;
    localparam int LOCK_CTRL = 8;
    localparam int TIMEOUT   = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .DWELL     (DWELL),
        .LOCK_CTRL (LOCK_CTRL),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [9:0] m_prev;
    int         m_slip, m_dwell, m_run, m_idle;
    bit         m_locked;
    bit         mp1_vld, mp1_qual, mp1_ctrl;
    logic [1:0] mp1_c;
    logic [7:0] mp1_d;
    bit         e_ov, e_de, e_c0, e_c1;
    logic [7:0] e_data;

    bit          cap_en = 1'b0;
    logic [10:0] mcap[$];
    logic [10:0] dcap[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [9:0] rot3(input logic [9:0] t);
        return {t[6:0], t[9:7]};
    endfunction

    // Window bit b is bit (slip+b) of the earliest-first stream prev,raw.
    function automatic logic [9:0] ref_window(input logic [9:0] r, input logic [9:0] p, input int s);
        logic [9:0] w;
        for (int b = 0; b < 10; b++) begin
            w[b] = (s + b < 10) ? p[s + b] : r[s + b - 10];
        end
        return w;
    endfunction

    function automatic int ref_token_index(input logic [9:0] w);
        logic [9:0] toks [4];
        toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int k = 0; k < 4; k++) if (w == toks[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_slip = 0; m_dwell = 0; m_run = 0; m_idle = 0; m_locked = 0;
        mp1_vld = 0; mp1_qual = 0; mp1_ctrl = 0; mp1_c = '0; mp1_d = '0;
        e_ov = 0; e_de = 0; e_c0 = 0; e_c1 = 0; e_data = '0;
    endtask

    task automatic model_edge(input logic [9:0] r, input logic v);
        logic [9:0] w;
        logic [7:0] q, x, d;
        int tk;
        e_ov = mp1_vld && mp1_qual;
        if (e_ov) begin
            e_de = !mp1_ctrl;
            if (mp1_ctrl) begin
                e_data = 8'h00; e_c0 = mp1_c[0]; e_c1 = mp1_c[1];
            end else begin
                e_data = mp1_d;
            end
        end
        mp1_vld = v;
        if (v) begin
            w  = ref_window(r, m_prev, m_slip);
            tk = ref_token_index(w);
            q  = w[9] ? ~w[7:0] : w[7:0];
            x  = q ^ {q[6:0], 1'b0};
            d  = w[8] ? x : ~x;
            d[0] = q[0];
            if (!m_locked) begin
                m_run = (tk >= 0) ? m_run + 1 : 0;
                m_dwell++;
                if (m_run == LOCK_CTRL) begin
                    m_locked = 1; m_idle = 0;
                end else if (m_dwell == DWELL) begin
                    m_slip = (m_slip + 1) % 10; m_dwell = 0; m_run = 0;
                end
            end else begin
                m_idle = (tk >= 0) ? 0 : m_idle + 1;
                if (m_idle == TIMEOUT) begin
                    m_locked = 0; m_dwell = 0; m_run = 0; m_idle = 0;
                end
            end
            mp1_qual = m_locked;
            mp1_ctrl = (tk >= 0);
            mp1_c    = (tk >= 0) ? 2'(tk) : 2'b00;
            mp1_d    = d;
            m_prev   = r;
        end
    endtask

    task automatic compare_all();
        check("locked",    32'(bus.locked),    32'(m_locked));
        check("slip",      32'(bus.slip),      32'(m_slip));
        check("out_valid", 32'(bus.out_valid), 32'(e_ov));
        check("de",        32'(bus.de),        32'(e_de));
        check("c0",        32'(bus.c0),        32'(e_c0));
        check("c1",        32'(bus.c1),        32'(e_c1));
        check("data",      32'(bus.data),      32'(e_data));
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample
    // at the next falling edge.
    task automatic cyc(input logic [9:0] r, input logic v);
        bus.raw = r;
        bus.raw_valid = v;
        @(posedge clk);
        if (rst_n) model_edge(r, v);
        @(negedge clk);
        compare_all();
        if (cap_en) begin
            if (e_ov) mcap.push_back({e_de, e_c1, e_c0, e_data});
            if (bus.out_valid) dcap.push_back({bus.de, bus.c1, bus.c0, bus.data});
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) cyc(10'($urandom), 1'($urandom));
        rst_n = 1'b1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        do_reset(2);
    endtask

    task automatic lock_count(input string tag, input logic [9:0] r);
        int n = 0;
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            cyc(r, 1'b1);
            n++;
            got = bus.locked;
        end
        check(tag, 32'(n), 32'(3 * DWELL + LOCK_CTRL));
    endtask

    logic [9:0] list_w [20];

    task automatic run_list(input bit gaps);
        do_reset(2);
        repeat (LOCK_CTRL + 1) cyc(10'h354, 1'b1);
        cap_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(list_w[i], 1'b1);
            if (gaps) repeat ($urandom_range(2, 0)) cyc(10'($urandom), 1'b0);
        end
        repeat (2) cyc(10'h354, 1'b1);
        repeat (3) cyc(10'h000, 1'b0);
        cap_en = 1'b0;
    endtask

    initial begin
        logic [9:0] toks [4];
        logic [10:0] ref_q[$];
        int ff_cnt;
        toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        bus.raw = '0;
        bus.raw_valid = 1'b0;
        @(negedge clk);

        // Reset with random inputs: every output must sit at zero.
        do_reset(6);

        // Aligned lock on 0x354, then two data words.
        repeat (LOCK_CTRL) cyc(10'h354, 1'b1);
        cyc(10'h200, 1'b1);
        check("lock_aligned", 32'(bus.locked), 32'd1);
        cyc(10'h100, 1'b1);
        cyc(10'h354, 1'b1);
        repeat (2) cyc(10'h354, 1'b1);

        // Random traffic while locked, with random valid gaps.
        for (int i = 0; i < 200; i++) begin
            logic [9:0] r;
            r = $urandom_range(1, 0) ? toks[$urandom_range(3, 0)] : 10'($urandom);
            cyc(r, 1'($urandom_range(3, 0) != 0));
        end

        // Loss of lock after TIMEOUT consecutive data words.
        repeat (2) cyc(10'h354, 1'b1);
        ff_cnt = 0;
        for (int i = 0; i < TIMEOUT + 12; i++) begin
            cyc(10'h200, 1'b1);
            if (bus.out_valid && bus.de && bus.data == 8'hFF) ff_cnt++;
        end
        check("loss_ff_pulses", 32'(ff_cnt), 32'(TIMEOUT - 1));
        check("loss_locked", 32'(bus.locked), 32'd0);
        check("loss_slip", 32'(bus.slip), 32'd0);

        // Stream misaligned by three bits.
        do_reset(2);
        lock_count("lock_words_fresh", rot3(10'h354));
        check("mis_slip", 32'(bus.slip), 32'd3);
        repeat (3) cyc(rot3(10'h0AB), 1'b1);
        check("mis_ctrl_valid", 32'(bus.out_valid), 32'd1);
        check("mis_ctrl_de", 32'(bus.de), 32'd0);
        check("mis_ctrl_c0", 32'(bus.c0), 32'd1);
        check("mis_ctrl_c1", 32'(bus.c1), 32'd0);
        repeat (4) cyc(rot3(toks[$urandom_range(3, 0)]), 1'b1);

        // Valid gaps must not change the decoded sequence.
        for (int i = 0; i < 20; i++)
            list_w[i] = $urandom_range(1, 0) ? toks[$urandom_range(3, 0)] : 10'($urandom);
        mcap.delete(); dcap.delete();
        run_list(1'b0);
        ref_q = mcap;
        mcap.delete(); dcap.delete();
        run_list(1'b1);
        check("gap_len", 32'(dcap.size()), 32'(ref_q.size()));
        for (int i = 0; i < dcap.size() && i < ref_q.size(); i++)
            check("gap_word", 32'(dcap[i]), 32'(ref_q[i]));

        // Asynchronous reset in the middle of a search at offset 5.
        do_reset(2);
        repeat (5 * DWELL + 3) cyc(10'h200, 1'b1);
        check("pre_reset_slip", 32'(bus.slip), 32'd5);
        async_reset();
        check("post_reset_slip", 32'(bus.slip), 32'd0);
        lock_count("lock_words_after_reset", rot3(10'h354));
        repeat (3) cyc(rot3(10'h354), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
